aes_round_serial: RTL and testbench
===================================

AES_ROUND_SERIAL -- requirements
Module: aes_round_serial

Interface
REQ-001 Parameter LANES, default 4, meaning bytes substituted per clock; legal values are 1, 2, 4, 8 and 16, and any other value SHALL cause an elaboration error.
REQ-002 Parameter BEATS, default 16/LANES, is derived and SHALL NOT be overridden.
REQ-003 clk  in  1  sole clock; all state SHALL update on its rising edge.
REQ-004 rst_n  in  1  reset, asynchronous assert and active low.
REQ-005 in_valid  in  1  a round request is present.
REQ-006 in_ready  out  1  block accepts a request this cycle.
REQ-007 mode  in  2  key length: 00 = AES-128, 01 = AES-192, 10 = AES-256; 11 SHALL be treated as 10.
REQ-008 round  in  4  round number, 0 to 14.
REQ-009 round_key  in  128  round key for this round.
REQ-010 data_in  in  128  state; byte i = data_in[8i+7:8i], column c = bytes 4c..4c+3, row r = byte 4c+r.
REQ-011 out_valid  out  1  data_out holds a completed round.
REQ-012 out_ready  in  1  consumer takes data_out.
REQ-013 data_out  out  128  round result, same byte layout as data_in.
REQ-014 busy  out  1  high in any state except IDLE.

Function
REQ-015 The FSM SHALL have four states: IDLE, ARK0, SUB, HOLD.
REQ-016 in_ready SHALL be 1 only in IDLE; a transfer occurs when in_valid and in_ready are both 1.
REQ-017 On transfer, mode, round, round_key and data_in SHALL be captured; later changes on these inputs SHALL have no effect on the current round.
REQ-018 On transfer with round == 0, the FSM SHALL go to ARK0.
- ARK0 lasts 1 cycle and computes data_out = data_in XOR round_key (no SubBytes, ShiftRows or MixColumns).
- The FSM then goes to HOLD.
REQ-019 On transfer with round != 0, the FSM SHALL go to SUB.
- ShiftRows is applied to the captured state.
- A beat counter runs 0..BEATS-1; beat b substitutes shifted bytes b*LANES .. b*LANES+LANES-1 through LANES aes_sbox instances.
REQ-020 Substituted bytes SHALL be collected in a 128-bit accumulator.
- With LANES >= 4: each completed column is MixColumn'd in the beat that produces it.
- With LANES < 4: a column is MixColumn'd in the beat that delivers its row-3 byte.
REQ-021 The last round is 10 for mode 00, 12 for mode 01 and 14 for modes 10/11.
- In the last round, MixColumns SHALL be bypassed and the substituted bytes accumulated directly.
- For any other nonzero round, including out-of-range values, MixColumns SHALL be applied.
REQ-022 In the cycle after beat BEATS-1, data_out SHALL be loaded with accumulator XOR round_key, and the FSM SHALL enter HOLD.
REQ-023 Latency from transfer edge to out_valid = 1:
- round 0: 1 cycle;
- other rounds: BEATS+1 cycles (LANES = 16 gives 2, LANES = 1 gives 17).
REQ-024 In HOLD, out_valid SHALL be 1 and data_out SHALL remain stable until out_ready = 1.
- On that edge, the FSM returns to IDLE and out_valid falls.
- A new transfer can occur no earlier than the following cycle.
REQ-025 If out_ready is already 1 when HOLD is entered, out_valid SHALL still be high for exactly one cycle.
REQ-026 in_valid outside IDLE SHALL be ignored and SHALL NOT alter state.
REQ-027 The beat counter SHALL wrap to 0 on leaving SUB; no partial result SHALL ever appear on data_out with out_valid = 1.
REQ-028 GF(2^8) doubling SHALL reduce by 0x1B; MixColumns row coefficients are [02 03 01 01] rotated per row.

Reset
REQ-029 While rst_n = 0:
- state = IDLE;
- beat counter = 0, accumulator = 0, data_out = 0;
- out_valid = 0, busy = 0, in_ready = 0.
REQ-030 in_ready SHALL rise in the first cycle after rst_n deasserts.
REQ-031 Asserting rst_n low mid-SUB or mid-HOLD SHALL abandon the round immediately, and the abandoned round SHALL never be output.

Verification
REQ-032 Round-0 check.
- Stimulus: LANES = 4, round 0, data_in = 0x00112233445566778899AABBCCDDEEFF, round_key = 0x000102030405060708090A0B0C0D0E0F.
- Required: data_out = 0x00102030405060708090A0B0C0D0E0F0, with out_valid 1 cycle after transfer.
REQ-033 All-zero middle round.
- Stimulus: mode 00, round 1, data_in = 0, key = 0, for each legal LANES.
- Required: every byte of data_out = 0x63, with out_valid exactly BEATS+1 cycles after transfer.
REQ-034 MixColumns versus final-round bypass.
- Stimulus: data_in all bytes 0x52 except byte 0 = 0x09, key = 0.
- Required, round 1: bytes 0..3 = 02, 01, 01, 03, all others 00.
- Required, mode 00 round 10: byte 0 = 01, all others 00.
- Required, mode 01: round 10 gives the mixed result and round 12 gives the bypass result.
- Required, mode 11: behaves as mode 10.
REQ-035 Back-pressure.
- Stimulus: out_ready held 0 for 5 cycles in HOLD, with in_valid held 1 throughout.
- Required: data_out stable, in_ready 0 and no new transfer during those cycles; the return to IDLE happens on the out_ready edge.
REQ-036 Mid-round reset.
- Stimulus: rst_n pulsed low during beat 2 of a LANES = 1 round.
- Required: out_valid 0 and data_out 0 immediately; in_ready 1 one cycle after release; the next round's result is correct.
REQ-037 Input capture.
- Stimulus: data_in and round_key changed every cycle during SUB.
- Required: the result equals the value computed from the inputs captured at transfer.

Source files
------------

// File: rtl/aes_sbox.sv
// AES forward S-box, purely combinational.
// The byte is inverted in GF(2^8) (modulus x^8+x^4+x^3+x+1) by raising it to
// the 254th power, then passed through the AES affine transform. Zero maps to
// zero before the affine step, which gives S(0) = 0x63.
//
// Ports:
//   a  in  8  byte to substitute
//   y  out 8  substituted byte
module aes_sbox (
  input  logic [7:0] a,
  output logic [7:0] y
);

  function automatic logic [7:0] xtime(input logic [7:0] v);
    return {v[6:0], 1'b0} ^ (v[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] p, input logic [7:0] q);
    logic [7:0] r, t, s;
    r = 8'h00;
    t = p;
    s = q;
    for (int i = 0; i < 8; i++) begin
      if (s[0]) r = r ^ t;
      t = xtime(t);
      s = s >> 1;
    end
    return r;
  endfunction

  logic [7:0] x2, x3, x6, x12, x15, x30, x60, x120, x240, x252, inv;

  // Addition chain for a^254 = a^-1.
  assign x2   = gmul(a, a);
  assign x3   = gmul(x2, a);
  assign x6   = gmul(x3, x3);
  assign x12  = gmul(x6, x6);
  assign x15  = gmul(x12, x3);
  assign x30  = gmul(x15, x15);
  assign x60  = gmul(x30, x30);
  assign x120 = gmul(x60, x60);
  assign x240 = gmul(x120, x120);
  assign x252 = gmul(x240, x12);
  assign inv  = gmul(x252, x2);

  assign y = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
           ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;

endmodule

// File: rtl/aes_round_serial.sv
// Byte-serial AES encryption round. One request (state, round key, round
// number, key length) is accepted in IDLE. Round 0 is a plain AddRoundKey.
// Other rounds apply ShiftRows, then substitute LANES bytes per clock,
// MixColumns each column as soon as it is complete (skipped in the final
// round), and finish with AddRoundKey one cycle after the last beat. The
// result is held until the consumer takes it.
//
// Ports:
//   clk        in   1    clock, rising edge
//   rst_n      in   1    asynchronous active-low reset
//   in_valid   in   1    round request present
//   in_ready   out  1    request accepted this cycle (IDLE only)
//   mode       in   2    00 AES-128, 01 AES-192, 10/11 AES-256
//   round      in   4    round number
//   round_key  in   128  round key
//   data_in    in   128  state, byte i = [8i+7:8i], row r of column c = byte 4c+r
//   out_valid  out  1    data_out holds a completed round
//   out_ready  in   1    consumer takes data_out
//   data_out   out  128  round result
//   busy       out  1    not IDLE
module aes_round_serial #(
  parameter int LANES = 4,
  parameter int BEATS = 16 / LANES
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [1:0]   mode,
  input  logic [3:0]   round,
  input  logic [127:0] round_key,
  input  logic [127:0] data_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] data_out,
  output logic         busy
);

  localparam int CW = (BEATS > 1) ? $clog2(BEATS) : 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] ARK0 = 2'd1;
  localparam logic [1:0] SUB  = 2'd2;
  localparam logic [1:0] HOLD = 2'd3;

  if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8 || LANES == 16)) begin : g_bad_lanes
    $error("aes_round_serial: LANES must be 1, 2, 4, 8 or 16");
  end
  if (BEATS * LANES != 16) begin : g_bad_beats
    $error("aes_round_serial: BEATS is derived from LANES and must not be overridden");
  end

  function automatic logic [7:0] xtime(input logic [7:0] v);
    return {v[6:0], 1'b0} ^ (v[7] ? 8'h1b : 8'h00);
  endfunction

  // Rows use coefficients [02 03 01 01] rotated right by the row index.
  function automatic logic [31:0] mix_col(input logic [7:0] a0, input logic [7:0] a1,
                                          input logic [7:0] a2, input logic [7:0] a3);
    logic [7:0] r0, r1, r2, r3;
    r0 = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
    r1 = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
    r2 = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
    r3 = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    return {r3, r2, r1, r0};
  endfunction

  logic [1:0]    state;
  logic [CW-1:0] beat;
  logic          fin;
  logic          alive;
  logic [127:0]  acc;
  logic [127:0]  acc_fin;
  logic [1:0]    mode_q;
  logic [3:0]    round_q;
  logic [127:0]  key_q;
  logic [127:0]  data_q;
  logic          last_rnd;
  logic          xfer;
  logic [3:0]    base;
  logic [7:0]    sh_b    [16];
  logic [7:0]    nxt_b   [16];
  logic [7:0]    lane_in [LANES];
  logic [7:0]    sub     [LANES];

  // alive holds in_ready low until the first clock edge after reset release.
  assign in_ready  = alive && (state == IDLE);
  assign out_valid = (state == HOLD);
  assign busy      = (state != IDLE);
  assign xfer      = in_valid && in_ready;
  assign base      = 4'(int'(beat) * LANES);
  assign last_rnd  = (round_q == ((mode_q == 2'b00) ? 4'd10 :
                                  (mode_q == 2'b01) ? 4'd12 : 4'd14));

  // ShiftRows: row r of column c takes row r of column (c+r) mod 4.
  for (genvar c = 0; c < 4; c++) begin : g_shift_col
    for (genvar r = 0; r < 4; r++) begin : g_shift_row
      assign sh_b[4*c+r] = data_q[8*(4*((c+r)%4)+r) +: 8];
    end
  end

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    assign lane_in[l] = sh_b[base + 4'(l)];
    aes_sbox u_sbox (.a(lane_in[l]), .y(sub[l]));
  end

  // Accumulator with this beat's substituted bytes merged in.
  for (genvar i = 0; i < 16; i++) begin : g_byte
    assign nxt_b[i] = (beat == CW'(i / LANES)) ? sub[i % LANES] : acc[8*i +: 8];
  end

  // A column is complete in the beat that delivers its row-3 byte; with
  // LANES >= 4 that is the same beat that delivers the whole column.
  for (genvar c = 0; c < 4; c++) begin : g_mix
    logic [31:0] mixed;
    logic        col_done;
    assign col_done = !last_rnd && (beat == CW'((4*c+3) / LANES));
    assign mixed    = mix_col(nxt_b[4*c], nxt_b[4*c+1], nxt_b[4*c+2], nxt_b[4*c+3]);
    assign acc_fin[32*c +: 32] = col_done ? mixed
                               : {nxt_b[4*c+3], nxt_b[4*c+2], nxt_b[4*c+1], nxt_b[4*c]};
  end

  // Request capture: inputs are sampled only on the transfer edge.
  always_ff @(posedge clk) begin
    if (xfer) begin
      mode_q  <= mode;
      round_q <= round;
      key_q   <= round_key;
      data_q  <= data_in;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      beat     <= '0;
      fin      <= 1'b0;
      alive    <= 1'b0;
      acc      <= '0;
      data_out <= '0;
    end else begin
      alive <= 1'b1;
      case (state)
        IDLE: begin
          if (xfer) state <= (round == 4'd0) ? ARK0 : SUB;
        end
        ARK0: begin
          data_out <= data_q ^ key_q;
          state    <= HOLD;
        end
        SUB: begin
          // fin marks the AddRoundKey cycle that follows the last beat.
          if (fin) begin
            data_out <= acc ^ key_q;
            fin      <= 1'b0;
            state    <= HOLD;
          end else begin
            acc <= acc_fin;
            if (beat == CW'(BEATS - 1)) begin
              beat <= '0;
              fin  <= 1'b1;
            end else begin
              beat <= beat + 1'b1;
            end
          end
        end
        HOLD: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_round_serial.sv
// Bench for aes_round_serial. Five instances (LANES = 1, 2, 4, 8, 16) share
// clock, reset and the data inputs; each has its own handshake. Expected
// results come from constant vectors and from a matrix-form AES round model
// whose S-box table is built by brute-force inversion in GF(2^8).
module tb_aes_round_serial;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [1:0]   mode = 2'd0;
  logic [3:0]   round = 4'd0;
  logic [127:0] round_key = '0;
  logic [127:0] data_in = '0;
  logic [4:0]   in_valid_v = '0;
  logic [4:0]   in_ready_v;
  logic [4:0]   out_valid_v;
  logic [4:0]   out_ready_v = '1;
  logic [4:0]   busy_v;
  logic [127:0] data_out_v [5];

  int total = 0;
  int bad   = 0;
  logic [7:0] sbox_t [256];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 5; g++) begin : g_dut
    aes_round_serial #(.LANES(1 << g)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid_v[g]), .in_ready(in_ready_v[g]),
      .mode(mode), .round(round), .round_key(round_key), .data_in(data_in),
      .out_valid(out_valid_v[g]), .out_ready(out_ready_v[g]),
      .data_out(data_out_v[g]), .busy(busy_v[g])
    );
  end

  initial begin
    #800000;
    $display("FAIL watchdog: got no finish, want finish before time limit");
    $fatal(1, "bench time limit reached");
  end

  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    logic [15:0] p;
    p = '0;
    for (int i = 0; i < 8; i++)
      if (((b >> i) & 8'h01) != 8'h00) p = p ^ (16'(a) << i);
    for (int i = 15; i >= 8; i--)
      if (((p >> i) & 16'h0001) != 16'h0000) p = p ^ (16'h011b << (i - 8));
    return p[7:0];
  endfunction

  task automatic build_sbox();
    for (int x = 0; x < 256; x++) begin
      logic [7:0] inv, s, bitv;
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gm(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      s = 8'h00;
      for (int i = 0; i < 8; i++) begin
        bitv = ((inv >> i) ^ (inv >> ((i + 4) % 8)) ^ (inv >> ((i + 5) % 8)) ^
                (inv >> ((i + 6) % 8)) ^ (inv >> ((i + 7) % 8)) ^ (8'h63 >> i)) & 8'h01;
        s = s | (bitv << i);
      end
      sbox_t[8'(x)] = s;
    end
  endtask

  function automatic logic [127:0] model(input logic [1:0] m, input logic [3:0] rnd,
                                         input logic [127:0] k, input logic [127:0] d);
    logic [7:0]   s [4][4];
    logic [7:0]   t [4][4];
    logic [7:0]   u [4][4];
    logic [127:0] o;
    int           last;
    if (rnd == 4'd0) return d ^ k;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) s[r][c] = 8'(d >> (8 * (4 * c + r)));
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) t[r][c] = sbox_t[s[r][(c + r) % 4]];
    last = (m == 2'd0) ? 10 : (m == 2'd1) ? 12 : 14;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        u[r][c] = (int'(rnd) == last) ? t[r][c] :
                  gm(8'h02, t[r][c]) ^ gm(8'h03, t[(r + 1) % 4][c]) ^
                  t[(r + 2) % 4][c] ^ t[(r + 3) % 4][c];
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) o = o | (128'(u[r][c]) << (8 * (4 * c + r)));
    return o ^ k;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, want);
    end
  endtask

  // One request on instance g; measures latency, result and one-cycle out_valid.
  task automatic do_round(input logic [2:0] g, input logic [1:0] m, input logic [3:0] rnd,
                          input logic [127:0] k, input logic [127:0] d,
                          input logic [127:0] want, input int lat, input bit scramble,
                          input string nm);
    int cyc;
    bit got;
    @(posedge clk); #1;
    chk({nm, " rdy"}, 128'(in_ready_v[g]), 128'd1);
    mode = m; round = rnd; round_key = k; data_in = d;
    in_valid_v[g] = 1'b1;
    @(posedge clk); #1;
    in_valid_v[g] = 1'b0;
    cyc = 0;
    got = 1'b0;
    while (!got && cyc < 40) begin
      if (scramble) begin
        data_in = rnd128(); round_key = rnd128();
        mode = 2'($urandom); round = 4'($urandom);
      end
      @(posedge clk); #1;
      cyc++;
      if (out_valid_v[g]) got = 1'b1;
    end
    chk({nm, " lat"}, 128'(cyc), 128'(lat));
    chk({nm, " data"}, data_out_v[g], want);
    @(posedge clk); #1;
    chk({nm, " pulse"}, 128'(out_valid_v[g]), 128'd0);
  endtask

  typedef struct {
    logic [1:0]   m;
    logic [3:0]   rnd;
    logic [127:0] k;
    logic [127:0] d;
    logic [127:0] want;
  } vec_t;

  initial begin : main
    vec_t         vt [12];
    logic [127:0] pat, mixd, kk, k, d, want;
    logic [2:0]   g;
    logic [1:0]   m;
    logic [3:0]   rnd;
    int           cyc;
    bit           seen;

    pat  = 128'h52525252_52525252_52525252_52525209;
    mixd = 128'h00000000_00000000_00000000_03010102;
    kk   = 128'h0f1e2d3c_4b5a6978_8796a5b4_c3d2e1f0;
    vt[0]  = '{2'd0, 4'd0,  128'h000102030405060708090A0B0C0D0E0F,
               128'h00112233445566778899AABBCCDDEEFF,
               128'h00102030405060708090A0B0C0D0E0F0};
    vt[1]  = '{2'd0, 4'd1,  '0, '0, {16{8'h63}}};
    vt[2]  = '{2'd0, 4'd1,  '0, pat, mixd};
    vt[3]  = '{2'd0, 4'd10, '0, pat, 128'd1};
    vt[4]  = '{2'd1, 4'd10, '0, pat, mixd};
    vt[5]  = '{2'd1, 4'd12, '0, pat, 128'd1};
    vt[6]  = '{2'd3, 4'd12, '0, pat, mixd};
    vt[7]  = '{2'd3, 4'd14, '0, pat, 128'd1};
    vt[8]  = '{2'd2, 4'd14, '0, pat, 128'd1};
    vt[9]  = '{2'd0, 4'd15, '0, pat, mixd};
    vt[10] = '{2'd2, 4'd1,  kk, pat, mixd ^ kk};
    vt[11] = '{2'd1, 4'd0,  kk, pat, pat ^ kk};

    build_sbox();

    // Reset state
    @(posedge clk); @(posedge clk); #1;
    chk("reset out_valid", 128'(out_valid_v), 128'd0);
    chk("reset in_ready", 128'(in_ready_v), 128'd0);
    chk("reset busy", 128'(busy_v), 128'd0);
    for (int i = 0; i < 5; i++) chk($sformatf("reset data_out%0d", i), data_out_v[i], '0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("in_ready after reset", 128'(in_ready_v), 128'h1f);

    // Constant vectors on the LANES=4 instance
    for (int i = 0; i < 12; i++)
      do_round(3'd2, vt[i].m, vt[i].rnd, vt[i].k, vt[i].d, vt[i].want,
               (vt[i].rnd == 4'd0) ? 1 : 5, 1'b0, $sformatf("vec%0d", i));

    // All-zero middle round on every LANES value
    for (int i = 0; i < 5; i++)
      do_round(3'(i), 2'd0, 4'd1, '0, '0, {16{8'h63}}, (16 >> i) + 1, 1'b0,
               $sformatf("zero lanes%0d", 1 << i));

    // Random rounds against the model, inputs scrambled after transfer on odd runs
    for (int n = 0; n < 50; n++) begin
      g = 3'($urandom_range(0, 4));
      m = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 3))
        0:       rnd = 4'd0;
        1:       rnd = 4'(10 + 2 * $urandom_range(0, 2));
        default: rnd = 4'($urandom_range(1, 15));
      endcase
      k = rnd128();
      d = rnd128();
      do_round(g, m, rnd, k, d, model(m, rnd, k, d),
               (rnd == 4'd0) ? 1 : (16 >> g) + 1, (n % 2) == 1, $sformatf("rand%0d", n));
    end

    // Back-pressure with in_valid held high throughout
    k = rnd128();
    d = rnd128();
    want = model(2'd0, 4'd3, k, d);
    @(posedge clk); #1;
    out_ready_v[2] = 1'b0;
    mode = 2'd0; round = 4'd3; round_key = k; data_in = d;
    in_valid_v[2] = 1'b1;
    @(posedge clk); #1;
    cyc = 0;
    while (!out_valid_v[2] && cyc < 40) begin
      data_in = rnd128(); round_key = rnd128();
      @(posedge clk); #1;
      cyc++;
    end
    chk("bp lat", 128'(cyc), 128'd5);
    chk("bp data", data_out_v[2], want);
    for (int i = 0; i < 5; i++) begin
      data_in = rnd128(); round_key = rnd128();
      @(posedge clk); #1;
      chk($sformatf("bp hold data%0d", i), data_out_v[2], want);
      chk($sformatf("bp hold valid%0d", i), 128'(out_valid_v[2]), 128'd1);
      chk($sformatf("bp hold ready%0d", i), 128'(in_ready_v[2]), 128'd0);
    end
    out_ready_v[2] = 1'b1;
    @(posedge clk); #1;
    chk("bp release valid", 128'(out_valid_v[2]), 128'd0);
    chk("bp release ready", 128'(in_ready_v[2]), 128'd1);
    chk("bp release busy", 128'(busy_v[2]), 128'd0);
    in_valid_v[2] = 1'b0;

    // Reset during beat 2 of a LANES=1 round
    @(posedge clk); #1;
    mode = 2'd0; round = 4'd1; round_key = rnd128(); data_in = rnd128();
    in_valid_v[0] = 1'b1;
    @(posedge clk); #1;
    in_valid_v[0] = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("mid reset out_valid", 128'(out_valid_v), 128'd0);
    chk("mid reset data_out", data_out_v[0], '0);
    chk("mid reset busy", 128'(busy_v[0]), 128'd0);
    chk("mid reset in_ready", 128'(in_ready_v[0]), 128'd0);
    @(posedge clk); @(posedge clk); @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("ready after mid reset", 128'(in_ready_v[0]), 128'd1);
    seen = 1'b0;
    repeat (25) begin
      @(posedge clk); #1;
      if (out_valid_v[0]) seen = 1'b1;
    end
    chk("abandoned round output", 128'(seen), 128'd0);
    k = rnd128();
    d = rnd128();
    do_round(3'd0, 2'd0, 4'd1, k, d, model(2'd0, 4'd1, k, d), 17, 1'b1, "after reset");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
